// File: rtl/sdr_pkg.sv
// Shared receiver definitions: PWM scale helpers, signed saturation and the audio FSM encoding.
package sdr_pkg;

    typedef enum logic {
        StRamp = 1'b0,
        StRun  = 1'b1
    } pwm_state_e;

    function automatic int unsigned pwm_max(input int unsigned bits);
        return (32'd1 << bits) - 32'd1;
    endfunction

    function automatic int unsigned pwm_mid(input int unsigned bits);
        return 32'd1 << (bits - 32'd1);
    endfunction

    // Clamp a signed value into the two's-complement range of 'width' bits.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] value,
                                                      input int unsigned        width);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (width - 32'd1)) - 32'sd1;
        lo = -(32'sd1 <<< (width - 32'd1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/audio_gain_sat.sv
// Shift-based volume gain with saturation to a signed PWM_BITS-wide sample.
module audio_gain_sat
    import sdr_pkg::*;
#(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic signed [8:0]          ac,
    input  logic        [2:0]          volume,
    output logic signed [PWM_BITS-1:0] sat
);

    logic signed [15:0] ac_ext;
    logic signed [15:0] shifted;
    logic signed [31:0] clamped;

    // Shift at full 16-bit width so no gain setting can wrap before the clamp.
    always_comb begin
        ac_ext  = {{7{ac[8]}}, ac};
        shifted = ac_ext <<< volume;
        clamped = sat_signed({{16{shifted[15]}}, shifted}, PWM_BITS);
    end

    assign sat = PWM_BITS'(clamped);

endmodule

// File: rtl/audio_pwm_out.sv
// Audio output stage: per-period envelope sampling, DC removal, volume gain and PWM drive
// with a soft-start ramp and mute.
module audio_pwm_out
    import sdr_pkg::*;
#(
    parameter int unsigned PWM_BITS  = 8,
    parameter int unsigned DC_SHIFT  = 8,
    parameter int unsigned RAMP_STEP = 16
) (
    input  logic              clk,
    input  logic              RSTb,
    input  logic signed [7:0] env_in,
    input  logic        [2:0] volume,
    input  logic              mute,
    output logic              pwm_out,
    output logic              sample_strobe
);

    localparam int unsigned AccW = 8 + DC_SHIFT + 1;
    localparam logic [PWM_BITS-1:0] CntMax  = PWM_BITS'(pwm_max(PWM_BITS));
    localparam logic [PWM_BITS-1:0] CntCap  = PWM_BITS'(pwm_max(PWM_BITS) - 32'd3);
    localparam logic [PWM_BITS-1:0] CntAc   = PWM_BITS'(pwm_max(PWM_BITS) - 32'd2);
    localparam logic [PWM_BITS-1:0] CntSat  = PWM_BITS'(pwm_max(PWM_BITS) - 32'd1);
    localparam logic [PWM_BITS-1:0] MidVal  = PWM_BITS'(pwm_mid(PWM_BITS));
    localparam logic [PWM_BITS-1:0] StepVal = PWM_BITS'(RAMP_STEP);

    logic        [PWM_BITS-1:0] cnt_q;
    logic        [PWM_BITS-1:0] duty_q;
    logic        [PWM_BITS-1:0] duty_next;
    logic        [PWM_BITS-1:0] ramp_q;
    logic        [PWM_BITS-1:0] ramp_d;
    pwm_state_e                 state_q;
    pwm_state_e                 state_d;
    logic signed [7:0]          s0_q;
    logic signed [8:0]          ac_q;
    logic signed [8:0]          ac_d;
    logic signed [PWM_BITS-1:0] sat_q;
    logic signed [PWM_BITS-1:0] sat_c;
    logic signed [AccW-1:0]     dc_acc_q;
    logic signed [AccW-1:0]     dc_acc_d;
    logic signed [AccW-1:0]     dc_int;
    logic signed [AccW-1:0]     s0_ext;
    logic                       pwm_q;
    logic                       strobe_q;
    logic                       wrap;

    audio_gain_sat #(
        .PWM_BITS (PWM_BITS)
    ) u_gain_sat (
        .ac     (ac_q),
        .volume (volume),
        .sat    (sat_c)
    );

    // DC tracker: ac uses the average from before this period's update.
    always_comb begin
        dc_int   = dc_acc_q >>> DC_SHIFT;
        s0_ext   = {{(AccW - 8){s0_q[7]}}, s0_q};
        dc_acc_d = dc_acc_q + s0_ext - dc_int;
        ac_d     = {s0_q[7], s0_q} - dc_int[8:0];
    end

    always_comb begin
        wrap      = (cnt_q == CntMax);
        duty_next = '0;
        state_d   = state_q;
        ramp_d    = ramp_q;
        unique case (state_q)
            StRamp:  duty_next = ramp_q;
            StRun:   duty_next = mute ? MidVal : {~sat_q[PWM_BITS-1], sat_q[PWM_BITS-2:0]};
            default: duty_next = '0;
        endcase
        if (wrap && state_q == StRamp) begin
            if (ramp_q == MidVal) begin
                state_d = StRun;
            end else begin
                ramp_d = ramp_q + StepVal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTb) begin
            state_q <= StRamp;
            ramp_q  <= '0;
        end else begin
            state_q <= state_d;
            ramp_q  <= ramp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTb) begin
            cnt_q    <= '0;
            duty_q   <= '0;
            s0_q     <= '0;
            ac_q     <= '0;
            sat_q    <= '0;
            dc_acc_q <= '0;
            pwm_q    <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_q + PWM_BITS'(1);
            pwm_q    <= (cnt_q < duty_q);
            strobe_q <= wrap;
            if (cnt_q == CntCap) begin
                s0_q <= env_in;
            end
            if (cnt_q == CntAc) begin
                ac_q     <= ac_d;
                dc_acc_q <= dc_acc_d;
            end
            if (cnt_q == CntSat) begin
                sat_q <= sat_c;
            end
            if (wrap) begin
                duty_q <= duty_next;
            end
        end
    end

    assign pwm_out       = pwm_q;
    assign sample_strobe = strobe_q;

endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out: duty is measured as pwm high count per strobe-aligned period.
module tb_audio_pwm_out;
    import sdr_pkg::*;

    typedef struct {
        logic signed [7:0] env;
        logic        [2:0] vol;
        logic              mte;
        int                exp_duty;
    } vec_t;

    localparam int NVec = 23;

    logic              clk = 1'b0;
    logic              RSTb = 1'b0;
    logic signed [7:0] env_in = '0;
    logic        [2:0] volume = '0;
    logic              mute = 1'b0;
    logic              pwm_out;
    logic              sample_strobe;

    logic              rst2b = 1'b0;
    logic signed [7:0] env2 = 8'sd40;
    logic        [2:0] vol2 = '0;
    logic              mute2 = 1'b0;
    logic              pwm2;
    logic              strobe2;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs [NVec];

    always #5 clk = ~clk;

    audio_pwm_out #(
        .PWM_BITS  (8),
        .DC_SHIFT  (8),
        .RAMP_STEP (16)
    ) dut (
        .clk           (clk),
        .RSTb          (RSTb),
        .env_in        (env_in),
        .volume        (volume),
        .mute          (mute),
        .pwm_out       (pwm_out),
        .sample_strobe (sample_strobe)
    );

    // Small instance so the DC tracker can converge within a short run.
    audio_pwm_out #(
        .PWM_BITS  (4),
        .DC_SHIFT  (4),
        .RAMP_STEP (2)
    ) dut2 (
        .clk           (clk),
        .RSTb          (rst2b),
        .env_in        (env2),
        .volume        (vol2),
        .mute          (mute2),
        .pwm_out       (pwm2),
        .sample_strobe (strobe2)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_range(input string name, input int actual, input int lo, input int hi);
        n_vec++;
        if (actual < lo || actual > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    task automatic sync_strobe(input string name);
        int found;
        found = 0;
        for (int i = 0; i < 600 && found == 0; i++) begin
            @(negedge clk);
            if (sample_strobe) found = 1;
        end
        check(name, found, 1);
    endtask

    // Called at a strobe cycle; counts the period just loaded, ends on the next strobe cycle.
    task automatic measure(output int hi, output int st);
        hi = 0;
        st = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            hi += int'(pwm_out);
            st += int'(sample_strobe);
        end
    endtask

    task automatic measure_check(input string name, input int exp_duty);
        int hi;
        int st;
        measure(hi, st);
        check({name, "_duty"}, hi, exp_duty);
        check({name, "_strobes"}, st, 1);
    endtask

    initial begin
        int hi;
        int st;
        int prev_exp;
        int found;

        vecs[0]  = '{8'sd10,   3'd2, 1'b0, 168};
        vecs[1]  = '{8'sd100,  3'd3, 1'b0, 255};
        vecs[2]  = '{-8'sd100, 3'd3, 1'b0, 0};
        vecs[3]  = '{-8'sd1,   3'd0, 1'b0, 127};
        vecs[4]  = '{8'sd127,  3'd0, 1'b0, 255};
        vecs[5]  = '{-8'sd128, 3'd0, 1'b0, 0};
        vecs[6]  = '{8'sd31,   3'd2, 1'b0, 252};
        vecs[7]  = '{8'sd32,   3'd2, 1'b0, 255};
        vecs[8]  = '{-8'sd32,  3'd2, 1'b0, 0};
        vecs[9]  = '{-8'sd33,  3'd2, 1'b0, 0};
        vecs[10] = '{8'sd1,    3'd7, 1'b0, 255};
        vecs[11] = '{-8'sd1,   3'd7, 1'b0, 0};
        vecs[12] = '{8'sd127,  3'd7, 1'b0, 255};
        vecs[13] = '{-8'sd128, 3'd7, 1'b0, 0};
        vecs[14] = '{8'sd127,  3'd0, 1'b0, 255};
        vecs[15] = '{8'sd127,  3'd0, 1'b0, 255};
        vecs[16] = '{8'sd127,  3'd0, 1'b0, 254};
        vecs[17] = '{8'sd127,  3'd0, 1'b1, 128};
        vecs[18] = '{8'sd127,  3'd0, 1'b1, 128};
        vecs[19] = '{8'sd127,  3'd0, 1'b1, 128};
        vecs[20] = '{8'sd127,  3'd0, 1'b0, 253};
        vecs[21] = '{8'sd0,    3'd2, 1'b0, 116};
        vecs[22] = '{8'sd0,    3'd0, 1'b0, 125};

        env_in = '0;
        repeat (3) @(negedge clk);
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_strobe", int'(sample_strobe), 0);
        check("reset_cnt", int'(dut.cnt_q), 0);
        RSTb  = 1'b1;
        rst2b = 1'b1;

        // Soft-start: loaded duties 0,16,..,128, then RUN at midscale.
        sync_strobe("ramp_sync");
        for (int k = 0; k < 9; k++) begin
            measure_check($sformatf("ramp[%0d]", k), 16 * k);
        end

        // Each row takes effect in the period after it is applied.
        prev_exp = 128;
        for (int k = 0; k < NVec; k++) begin
            env_in = vecs[k].env;
            volume = vecs[k].vol;
            mute   = vecs[k].mte;
            measure_check($sformatf("table[%0d]", k), prev_exp);
            prev_exp = vecs[k].exp_duty;
        end
        measure_check("table_last", prev_exp);

        // Mute asserted mid-period: that period is kept, the next one is midscale.
        env_in = 8'sd60;
        volume = 3'd0;
        mute   = 1'b0;
        measure_check("pre_mute", 125);
        hi = 0;
        st = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (i == 100) mute = 1'b1;
            hi += int'(pwm_out);
            st += int'(sample_strobe);
        end
        check("mute_mid_duty", hi, 185);
        check("mute_mid_strobes", st, 1);
        measure_check("mute_next", 128);
        // Tracker kept running while muted: dc_int is now 4, so 127-4 saturates at gain 8.
        env_in = 8'sd127;
        volume = 3'd3;
        mute   = 1'b0;
        measure_check("unmute_lag", 128);

        // Reset at cnt==M-2 in a full-duty period.
        repeat (253) @(negedge clk);
        check("pre_reset_cnt", int'(dut.cnt_q), 253);
        check("pre_reset_pwm", int'(pwm_out), 1);
        RSTb   = 1'b0;
        env_in = '0;
        volume = '0;
        @(negedge clk);
        check("rst_pwm", int'(pwm_out), 0);
        check("rst_strobe", int'(sample_strobe), 0);
        check("rst_cnt", int'(dut.cnt_q), 0);
        check("rst_state", int'(dut.state_q), int'(StRamp));
        RSTb = 1'b1;
        sync_strobe("rst_sync");
        measure_check("rst_ramp0", 0);
        measure_check("rst_ramp1", 16);

        // Small instance has held env=40 since reset; DC fully removed.
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clk);
            if (strobe2) found = 1;
        end
        check("dc_sync", found, 1);
        hi = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            hi += int'(pwm2);
        end
        check_range("dc_duty", hi, 7, 8);
        check_range("dc_int", int'(dut2.dc_int), 39, 40);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
